// File: rtl/param_alu.sv
// param_alu: handshaked ALU with single-cycle arithmetic/logic ops and
// iterative one-bit-per-cycle shifts.
//
// Optional feature: define PARAM_ALU_ROR_EN to enable opcode 111 as an
// iterative rotate-right. Without the macro, opcode 111 completes at once
// with RESULT 0 and ILLEGAL 1.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for a request; in_ready high
// SHIFT   | shifting the captured operand one bit per cycle
// DONE    | result held on the outputs until out_ready

module param_alu #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [2:0]       select,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             illegal
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_ROR = 3'b111;

    logic [1:0]       state;
    logic [WIDTH-1:0] res_q;
    logic [SHW-1:0]   cnt_q;
    logic [2:0]       kind_q;
    logic             ovf_q;
    logic             ill_q;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   n;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_ill;
    logic             is_shift;
    logic [WIDTH-1:0] shifted;

    assign sum  = op1 + op2;
    assign diff = op1 - op2;
    assign n    = op2[SHW-1:0];

    // Decode the request into a single-cycle result, or flag it as iterative.
    always_comb begin
        alu_res  = '0;
        alu_ovf  = 1'b0;
        alu_ill  = 1'b0;
        is_shift = 1'b0;
        case (select)
            OP_FWD: alu_res = op2;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
            end
            OP_AND: alu_res = op1 & op2;
            OP_OR:  alu_res = op1 | op2;
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (op1[WIDTH-1] != op2[WIDTH-1]) && (diff[WIDTH-1] != op1[WIDTH-1]);
            end
            OP_SLL: is_shift = 1'b1;
            OP_SRA: is_shift = 1'b1;
`ifdef PARAM_ALU_ROR_EN
            OP_ROR: is_shift = 1'b1;
`else
            OP_ROR: alu_ill = 1'b1;
`endif
            default: alu_res = '0;
        endcase
    end

    // One bit-position step of the captured shift operation.
    always_comb begin
        shifted = res_q;
        case (kind_q)
            OP_SLL:  shifted = {res_q[WIDTH-2:0], 1'b0};
            OP_SRA:  shifted = {res_q[WIDTH-1], res_q[WIDTH-1:1]};
            OP_ROR:  shifted = {res_q[0], res_q[WIDTH-1:1]};
            default: shifted = res_q;
        endcase
    end

    // Sequencing FSM: capture at accept, iterate shifts, hold until consumed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            res_q  <= '0;
            cnt_q  <= '0;
            kind_q <= OP_FWD;
            ovf_q  <= 1'b0;
            ill_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        kind_q <= select;
                        ovf_q  <= alu_ovf;
                        ill_q  <= alu_ill;
                        if (is_shift) begin
                            res_q <= op1;
                            cnt_q <= n;
                            state <= (n == '0) ? S_DONE : S_SHIFT;
                        end else begin
                            res_q <= alu_res;
                            state <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    res_q <= shifted;
                    cnt_q <= cnt_q - 1'b1;
                    // Last shift lands on the same edge that enters DONE.
                    if (cnt_q == SHW'(1))
                        state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign result    = res_q;
    assign zero      = (res_q == '0);
    assign neg       = res_q[WIDTH-1];
    assign ovf       = ovf_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_param_alu.sv
// Directed bench for param_alu (WIDTH=8).
module tb_param_alu;

    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] op1;
    logic [7:0] op2;
    logic [2:0] select;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       zero;
    logic       neg;
    logic       ovf;
    logic       illegal;

    int n_cmp = 0;
    int n_err = 0;

    param_alu #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .select    (select),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for exactly one accept edge.
    task automatic issue(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
        select   = sel;
        op1      = a;
        op2      = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op1       = '0;
        op2       = '0;
        select    = '0;
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 1);
        chk("rst_neg", neg, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_illegal", illegal, 0);
        step();
        reset_n = 1'b1;

        // ADD 127+1: signed overflow, one-cycle latency
        issue(3'b001, 8'd127, 8'd1);
        chk("add_valid", out_valid, 1);
        chk("add_result", result, 8'h80);
        chk("add_neg", neg, 1);
        chk("add_ovf", ovf, 1);
        chk("add_in_ready", in_ready, 0);
        drain();
        chk("add_back_idle", in_ready, 1);
        chk("add_valid_low", out_valid, 0);

        // SUB 3-3 and 3-7
        issue(3'b100, 8'd3, 8'd3);
        chk("sub0_result", result, 0);
        chk("sub0_zero", zero, 1);
        chk("sub0_ovf", ovf, 0);
        drain();
        issue(3'b100, 8'd3, 8'd7);
        chk("sub_neg_result", result, 8'hFC);
        chk("sub_neg_neg", neg, 1);
        chk("sub_neg_ovf", ovf, 0);
        drain();
        issue(3'b100, 8'h80, 8'h01);
        chk("sub_ovf_result", result, 8'h7F);
        chk("sub_ovf_ovf", ovf, 1);
        drain();

        // logic ops and forward
        issue(3'b010, 8'hCC, 8'hAA);
        chk("and_result", result, 8'h88);
        chk("and_ovf", ovf, 0);
        drain();
        issue(3'b011, 8'hCC, 8'hAA);
        chk("or_result", result, 8'hEE);
        drain();
        issue(3'b000, 8'h55, 8'h00);
        chk("fwd_result", result, 8'h00);
        chk("fwd_zero", zero, 1);
        drain();

        // SRA 0x90 by 3: valid four cycles after accept
        issue(3'b110, 8'h90, 8'd3);
        chk("sra_c1_valid", out_valid, 0);
        chk("sra_c1_ready", in_ready, 0);
        step();
        chk("sra_c2_valid", out_valid, 0);
        chk("sra_c2_ready", in_ready, 0);
        step();
        chk("sra_c3_valid", out_valid, 0);
        chk("sra_c3_ready", in_ready, 0);
        step();
        chk("sra_valid", out_valid, 1);
        chk("sra_result", result, 8'hF2);
        chk("sra_neg", neg, 1);
        drain();

        // SLL by 0 completes in one cycle; SLL 0x81 by 2
        issue(3'b101, 8'h5A, 8'd0);
        chk("sll0_valid", out_valid, 1);
        chk("sll0_result", result, 8'h5A);
        drain();
        issue(3'b101, 8'h81, 8'd2);
        chk("sll2_c1_valid", out_valid, 0);
        step();
        chk("sll2_c2_valid", out_valid, 0);
        step();
        chk("sll2_valid", out_valid, 1);
        chk("sll2_result", result, 8'h04);
        drain();

        // backpressure in DONE with a pending new request
        issue(3'b001, 8'h50, 8'h50);
        select   = 3'b011;
        op1      = 8'h0F;
        op2      = 8'hF0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_result", result, 8'hA0);
            chk("bp_valid", out_valid, 1);
            chk("bp_ovf", ovf, 1);
            step();
        end
        chk("bp_result_end", result, 8'hA0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release_idle", in_ready, 1);
        chk("bp_release_valid", out_valid, 0);
        step();
        in_valid = 1'b0;
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_result", result, 8'hFF);
        chk("bp_next_ovf", ovf, 0);
        drain();

        // reset in the middle of a shift
        issue(3'b110, 8'h80, 8'd7);
        step();
        chk("mid_shift_valid", out_valid, 0);
        reset_n = 1'b0;
        #1;
        chk("mr_valid", out_valid, 0);
        chk("mr_result", result, 0);
        chk("mr_zero", zero, 1);
        chk("mr_neg", neg, 0);
        chk("mr_in_ready", in_ready, 1);
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("mr_no_pulse", out_valid, 0);
            step();
        end

        // opcode 111
        issue(3'b111, 8'h01, 8'd1);
`ifdef PARAM_ALU_ROR_EN
        chk("ror_c1_valid", out_valid, 0);
        step();
        chk("ror_valid", out_valid, 1);
        chk("ror_result", result, 8'h80);
        chk("ror_illegal", illegal, 0);
`else
        chk("ror_valid", out_valid, 1);
        chk("ror_result", result, 8'h00);
        chk("ror_zero", zero, 1);
        chk("ror_illegal", illegal, 1);
`endif
        drain();

        // a legal op clears ILLEGAL
        issue(3'b001, 8'd2, 8'd3);
        chk("post_illegal", illegal, 0);
        chk("post_result", result, 8'd5);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/param_alu.md
PARAM_ALU -- requirements
Module: param_alu

Interface
REQ-001 Parameter WIDTH, default 8, datapath width in bits; SHALL be a power of two, at least 4.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width; SHALL NOT be overridden.
REQ-003 CLK  input  1  rising-edge clock; the block's only clock.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 IN_VALID  input  1  operation request valid.
REQ-006 IN_READY  output  1  block can accept a request.
REQ-007 OP1  input  WIDTH  first operand, two's complement.
REQ-008 OP2  input  WIDTH  second operand / shift amount (OP2[SHW-1:0]).
REQ-009 SELECT  input  3  opcode.
REQ-010 OUT_VALID  output  1  result valid.
REQ-011 OUT_READY  input  1  consumer accepts result.
REQ-012 RESULT  output  WIDTH  registered result.
REQ-013 ZERO  output  1  RESULT is all zeros.
REQ-014 NEG  output  1  RESULT[WIDTH-1].
REQ-015 OVF  output  1  signed overflow of ADD or SUB, else 0.
REQ-016 ILLEGAL  output  1  opcode not supported in this build.

Function
REQ-017 Opcodes SHALL be: 000 FWD (OP2), 001 ADD (OP1+OP2), 010 AND, 011 OR, 100 SUB (OP1-OP2), 101 SLL (OP1 << n), 110 SRA (OP1 >>> n), 111 ROR (Configuration); n = OP2[SHW-1:0].
REQ-018 ADD/SUB SHALL wrap modulo 2^WIDTH; OVF set when operand signs force an unrepresentable signed result.
REQ-019 FSM states SHALL be IDLE, SHIFT, DONE; IN_READY = 1 only in IDLE.
REQ-020 Request accepted on a rising edge with IN_VALID && IN_READY; OP1, OP2, SELECT captured at that edge; later input changes ignored until IDLE.
REQ-021 Opcodes 000-100: IDLE -> DONE at the accept edge; OUT_VALID high 1 cycle after accept.
REQ-022 Shift opcodes: operand and count n loaded at accept; n = 0 -> DONE directly; else IDLE -> SHIFT, one bit-position per cycle, SHIFT -> DONE when count reaches 0; OUT_VALID high n+1 cycles after accept.
REQ-023 SRA SHALL replicate OP1 sign bit; SLL shifts in zeros.
REQ-024 In DONE, RESULT, ZERO, NEG, OVF, ILLEGAL SHALL hold stable while OUT_VALID=1 and OUT_READY=0.
REQ-025 DONE -> IDLE on edge with OUT_READY=1; no new request accepted on that same edge.
REQ-026 ZERO, NEG SHALL derive from the registered RESULT, never from unregistered inputs.
REQ-027 OUT_READY SHALL be ignored outside DONE; IN_VALID ignored outside IDLE.

Reset
REQ-028 RESET_N low SHALL immediately force state IDLE, shift counter 0, RESULT 0, OVF 0, ILLEGAL 0, OUT_VALID 0; ZERO 1, NEG 0; IN_READY 1 while RESET_N low.
REQ-029 Reset during SHIFT or DONE SHALL discard the operation; no OUT_VALID pulse follows.
REQ-030 Release of RESET_N SHALL be sampled synchronously; first accept possible on the first rising edge after release.

Configuration
REQ-031 Macro PARAM_ALU_ROR_EN: defined -> opcode 111 is rotate-right of OP1 by n, iterative, timing per REQ-022, ILLEGAL 0.
REQ-032 PARAM_ALU_ROR_EN undefined -> opcode 111 completes as a single-cycle op with RESULT 0, ZERO 1, ILLEGAL 1; no SHIFT state entered.

Verification
REQ-033 WIDTH=8: ADD OP1=8'd127, OP2=8'd1 -> RESULT 8'h80, NEG 1, OVF 1, OUT_VALID 1 cycle after accept.
REQ-034 SUB OP1=8'd3, OP2=8'd3 -> RESULT 0, ZERO 1, OVF 0; SUB 3-7 -> RESULT 8'hFC, NEG 1.
REQ-035 SRA OP1=8'h90, OP2=3 -> RESULT 8'hF2 exactly 4 cycles after accept; IN_READY 0 throughout; SLL OP2=0 -> RESULT=OP1 after 1 cycle.
REQ-036 OUT_READY held 0 for 5 cycles in DONE while IN_VALID=1 with new operands -> RESULT stable, no accept until cycle after OUT_READY=1.
REQ-037 Assert RESET_N low mid-SHIFT -> outputs at reset values within the same cycle, OUT_VALID never pulses for the aborted op.
REQ-038 Opcode 111 OP1=8'h01, OP2=1: with PARAM_ALU_ROR_EN -> 8'h80, ILLEGAL 0; without -> 8'h00, ILLEGAL 1 after 1 cycle.
